// File: rtl/rip_branch_history_if.sv
// Fetch/resolve bundle between the front end and the global branch-history unit.
// The master side is the pipeline; the slave side is rip_branch_history.
interface rip_branch_history_if #(
  parameter int HISTORY_LEN = 16,
  parameter int CKPT_DEPTH  = 4
);
  localparam int PTR_W = $clog2(CKPT_DEPTH);
  localparam int CNT_W = $clog2(CKPT_DEPTH + 1);

  logic                   pred_valid_i;
  logic                   pred_taken_i;
  logic                   pred_ready_o;
  logic [PTR_W-1:0]       pred_tag_o;
  logic                   resolve_valid_i;
  logic                   resolve_taken_i;
  logic [HISTORY_LEN-1:0] history_o;
  logic [HISTORY_LEN-1:0] commit_history_o;
  logic                   recover_o;
  logic [CNT_W-1:0]       inflight_o;

  modport master (
    output pred_valid_i, pred_taken_i, resolve_valid_i, resolve_taken_i,
    input  pred_ready_o, pred_tag_o, history_o, commit_history_o, recover_o, inflight_o
  );

  modport slave (
    input  pred_valid_i, pred_taken_i, resolve_valid_i, resolve_taken_i,
    output pred_ready_o, pred_tag_o, history_o, commit_history_o, recover_o, inflight_o
  );
endinterface

// File: rtl/rip_branch_history.sv
// Speculative/committed global branch history with checkpoint FIFO and mispredict rollback.
// Optional resolve/mispredict statistics counters: define RIP_BP_HISTORY_STATS_EN.
module rip_branch_history #(
  parameter int HISTORY_LEN = 16,
  parameter int CKPT_DEPTH  = 4
) (
  input  logic clk,
  input  logic rst,
`ifdef RIP_BP_HISTORY_STATS_EN
  output logic [31:0] stat_resolved_o,
  output logic [31:0] stat_mispredict_o,
`endif
  rip_branch_history_if.slave bh
);
  localparam int PTR_W = $clog2(CKPT_DEPTH);
  localparam int CNT_W = $clog2(CKPT_DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CKPT_DEPTH);

  logic [HISTORY_LEN-1:0] history_q, history_d;
  logic [HISTORY_LEN-1:0] commit_q, commit_d;
  logic [CKPT_DEPTH-1:0]  fifo_q, fifo_d;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   recover_q, recover_d;

  logic accept;
  logic resolve;
  logic mispredict;

  assign bh.pred_ready_o     = (count_q != CNT_FULL);
  assign bh.pred_tag_o       = wr_ptr_q;
  assign bh.history_o        = history_q;
  assign bh.commit_history_o = commit_q;
  assign bh.recover_o        = recover_q;
  assign bh.inflight_o       = count_q;

  assign accept     = bh.pred_valid_i & bh.pred_ready_o;
  assign resolve    = bh.resolve_valid_i & (count_q != '0);
  assign mispredict = resolve & (fifo_q[rd_ptr_q] != bh.resolve_taken_i);

  always_comb begin
    history_d = history_q;
    commit_d  = commit_q;
    fifo_d    = fifo_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    recover_d = mispredict;

    if (resolve) begin
      commit_d = {commit_q[HISTORY_LEN-2:0], bh.resolve_taken_i};
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end

    // A mispredict rebuilds history from the committed path and drops any wrong-path accept.
    if (mispredict) begin
      history_d = {commit_q[HISTORY_LEN-2:0], bh.resolve_taken_i};
      wr_ptr_d  = rd_ptr_q + PTR_ONE;
      count_d   = '0;
    end else begin
      if (accept) begin
        history_d        = {history_q[HISTORY_LEN-2:0], bh.pred_taken_i};
        fifo_d[wr_ptr_q] = bh.pred_taken_i;
        wr_ptr_d         = wr_ptr_q + PTR_ONE;
      end
      case ({accept, resolve})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      history_q <= '0;
      commit_q  <= '0;
      fifo_q    <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      recover_q <= 1'b0;
    end else begin
      history_q <= history_d;
      commit_q  <= commit_d;
      fifo_q    <= fifo_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      recover_q <= recover_d;
    end
  end

`ifdef RIP_BP_HISTORY_STATS_EN
  logic [31:0] stat_resolved_q, stat_resolved_d;
  logic [31:0] stat_mispredict_q, stat_mispredict_d;

  always_comb begin
    stat_resolved_d   = stat_resolved_q + (resolve ? 32'd1 : 32'd0);
    stat_mispredict_d = stat_mispredict_q + (mispredict ? 32'd1 : 32'd0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_resolved_q   <= '0;
      stat_mispredict_q <= '0;
    end else begin
      stat_resolved_q   <= stat_resolved_d;
      stat_mispredict_q <= stat_mispredict_d;
    end
  end

  assign stat_resolved_o   = stat_resolved_q;
  assign stat_mispredict_o = stat_mispredict_q;
`endif
endmodule

// File: tb/tb_rip_branch_history.sv
// Scoreboard bench for rip_branch_history: a queue-based model predicts each cycle's
// registered outputs, which are popped and compared one clock later.
module tb_rip_branch_history;
  localparam int HL = 16;
  localparam int D  = 4;

  typedef struct {
    logic [HL-1:0] hist;
    logic [HL-1:0] commit;
    logic          recover;
    int            inflight;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  rip_branch_history_if #(.HISTORY_LEN(HL), .CKPT_DEPTH(D)) bh ();

`ifdef RIP_BP_HISTORY_STATS_EN
  logic [31:0] stat_resolved;
  logic [31:0] stat_mispredict;
  rip_branch_history #(.HISTORY_LEN(HL), .CKPT_DEPTH(D)) dut (
    .clk              (clk),
    .rst              (rst),
    .stat_resolved_o  (stat_resolved),
    .stat_mispredict_o(stat_mispredict),
    .bh               (bh.slave)
  );
`else
  rip_branch_history #(.HISTORY_LEN(HL), .CKPT_DEPTH(D)) dut (
    .clk(clk),
    .rst(rst),
    .bh (bh.slave)
  );
`endif

  // Reference model state
  logic [HL-1:0] m_hist;
  logic [HL-1:0] m_commit;
  logic          m_q[$];
  int            m_wr;
  int            m_res;
  int            m_mis;
  exp_t          sb[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic modelReset();
    m_hist   = '0;
    m_commit = '0;
    m_q.delete();
    m_wr     = 0;
    m_res    = 0;
    m_mis    = 0;
    sb.delete();
  endtask

  task automatic applyStimulus(input logic pv, input logic pt, input logic rv, input logic rt);
    exp_t e;
    bit   ready;
    bit   acc;
    bit   res;
    bit   mis;
    int   rd;
    logic dir;
    @(negedge clk);
    bh.pred_valid_i    = pv;
    bh.pred_taken_i    = pt;
    bh.resolve_valid_i = rv;
    bh.resolve_taken_i = rt;
    #1;
    ready = (m_q.size() != D);
    checkOutput("pred_ready", 32'(bh.pred_ready_o), 32'(ready));
    checkOutput("pred_tag", 32'(bh.pred_tag_o), 32'(m_wr));

    acc = pv && ready;
    res = rv && (m_q.size() != 0);
    mis = 1'b0;
    if (res) begin
      rd  = (m_wr - m_q.size() + D) % D;
      dir = m_q.pop_front();
      mis = (dir != rt);
      m_commit = {m_commit[HL-2:0], rt};
      m_res++;
      if (mis) begin
        m_mis++;
        m_hist = m_commit;
        m_q.delete();
        m_wr = (rd + 1) % D;
      end
    end
    if (acc && !mis) begin
      m_hist = {m_hist[HL-2:0], pt};
      m_q.push_back(pt);
      m_wr = (m_wr + 1) % D;
    end
    e.hist     = m_hist;
    e.commit   = m_commit;
    e.recover  = mis;
    e.inflight = m_q.size();
    sb.push_back(e);

    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checkOutput("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      checkOutput("history", 32'(bh.history_o), 32'(e.hist));
      checkOutput("commit_history", 32'(bh.commit_history_o), 32'(e.commit));
      checkOutput("recover", 32'(bh.recover_o), 32'(e.recover));
      checkOutput("inflight", 32'(bh.inflight_o), 32'(e.inflight));
    end
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [HL-1:0] saved_hist;
    logic          rt;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bh.pred_valid_i    = 1'b0;
    bh.pred_taken_i    = 1'b0;
    bh.resolve_valid_i = 1'b0;
    bh.resolve_taken_i = 1'b0;
    modelReset();
    repeat (2) @(negedge clk);
    checkOutput("rst_history", 32'(bh.history_o), 32'd0);
    checkOutput("rst_ready", 32'(bh.pred_ready_o), 32'd1);
    rst = 1'b0;

    // Predictions T,N,T then in-order correct resolves
    applyStimulus(1, 1, 0, 0);
    applyStimulus(1, 0, 0, 0);
    applyStimulus(1, 1, 0, 0);
    checkOutput("tnt_history", 32'(bh.history_o), 32'h0005);
    checkOutput("tnt_inflight", 32'(bh.inflight_o), 32'd3);
    applyStimulus(0, 0, 1, 1);
    applyStimulus(0, 0, 1, 0);
    applyStimulus(0, 0, 1, 1);
    checkOutput("tnt_commit", 32'(bh.commit_history_o), 32'h0005);
    checkOutput("tnt_drained", 32'(bh.inflight_o), 32'd0);

    // Fill the FIFO, then an extra prediction must be ignored
    applyStimulus(1, 1, 0, 0);
    applyStimulus(1, 0, 0, 0);
    applyStimulus(1, 0, 0, 0);
    applyStimulus(1, 1, 0, 0);
    checkOutput("full_ready", 32'(bh.pred_ready_o), 32'd0);
    saved_hist = bh.history_o;
    applyStimulus(1, 1, 0, 0);
    checkOutput("full_hist_hold", 32'(bh.history_o), 32'(saved_hist));
    checkOutput("full_inflight", 32'(bh.inflight_o), 32'd4);
    applyStimulus(0, 0, 1, 1);
    checkOutput("drain_ready", 32'(bh.pred_ready_o), 32'd1);
    applyStimulus(0, 0, 1, 0);
    applyStimulus(0, 0, 1, 0);
    applyStimulus(0, 0, 1, 1);

    // Asynchronous reset mid-operation with three branches in flight
    applyStimulus(1, 1, 0, 0);
    applyStimulus(1, 1, 0, 0);
    applyStimulus(1, 1, 0, 0);
    checkOutput("pre_rst_inflight", 32'(bh.inflight_o), 32'd3);
    bh.pred_valid_i = 1'b0;
    bh.resolve_valid_i = 1'b0;
    rst = 1'b1;
    #1;
    checkOutput("async_rst_history", 32'(bh.history_o), 32'd0);
    checkOutput("async_rst_commit", 32'(bh.commit_history_o), 32'd0);
    checkOutput("async_rst_inflight", 32'(bh.inflight_o), 32'd0);
    checkOutput("async_rst_recover", 32'(bh.recover_o), 32'd0);
    checkOutput("async_rst_ready", 32'(bh.pred_ready_o), 32'd1);
    checkOutput("async_rst_tag", 32'(bh.pred_tag_o), 32'd0);
    modelReset();
    @(negedge clk);
    rst = 1'b0;

    // From commit 0: T,T,T then a mispredicted resolve
    applyStimulus(1, 1, 0, 0);
    applyStimulus(1, 1, 0, 0);
    applyStimulus(1, 1, 0, 0);
    checkOutput("ttt_history", 32'(bh.history_o), 32'h0007);
    applyStimulus(0, 0, 1, 0);
    checkOutput("mis_recover", 32'(bh.recover_o), 32'd1);
    checkOutput("mis_history", 32'(bh.history_o), 32'h0000);
    checkOutput("mis_inflight", 32'(bh.inflight_o), 32'd0);
    idle();
    checkOutput("mis_recover_clear", 32'(bh.recover_o), 32'd0);

    // Same-cycle accept with correct resolve, then with mispredict
    applyStimulus(1, 1, 0, 0);
    applyStimulus(1, 0, 0, 0);
    applyStimulus(1, 1, 1, 1);
    checkOutput("acc_res_inflight", 32'(bh.inflight_o), 32'd2);
    applyStimulus(1, 0, 1, 1);
    checkOutput("acc_mis_inflight", 32'(bh.inflight_o), 32'd0);
    checkOutput("acc_mis_hist_eq", 32'(bh.history_o), 32'(bh.commit_history_o));

    // Repeated mispredicts, and a resolve with nothing in flight
    applyStimulus(1, 1, 0, 0);
    applyStimulus(0, 0, 1, 0);
    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 0, 1, 1);
    applyStimulus(0, 0, 1, 1);
    applyStimulus(0, 0, 1, 0);

    // Random traffic, resolves mostly matching the oldest prediction
    for (int i = 0; i < 300; i++) begin
      rt = (m_q.size() != 0) ? m_q[0] : 1'($urandom_range(0, 1));
      if ($urandom_range(0, 4) == 0) rt = ~rt;
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), rt);
    end

`ifdef RIP_BP_HISTORY_STATS_EN
    checkOutput("stat_resolved", stat_resolved, 32'(m_res));
    checkOutput("stat_mispredict", stat_mispredict, 32'(m_mis));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/rip_branch_history.md
Name: rip_branch_history

Overview:
- Global branch-history unit directly upstream of the branch predictor table.
- Keeps a speculative history register, shifted on every conditional-branch prediction made at fetch. The predictor uses it for gshare/perceptron indexing and as the perceptron history input.
- Keeps a committed history register, shifted on in-order branch resolution.
- Buffers the predicted directions of in-flight branches in a checkpoint FIFO, detects mispredicts, and rolls the speculative history back.

Parameters:
- HISTORY_LEN, 16, history length in bits; matches the predictor's HISTORY_LEN, minimum 2.
- CKPT_DEPTH, 4, maximum in-flight unresolved branches; power of two, minimum 2.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- pred_valid_i  in  1  fetch made a conditional-branch prediction this cycle.
- pred_taken_i  in  1  predicted direction.
- pred_ready_o  out  1  FIFO can accept a prediction.
- pred_tag_o  out  $clog2(CKPT_DEPTH)  FIFO slot assigned to the prediction accepted this cycle (current write pointer).
- resolve_valid_i  in  1  oldest in-flight branch resolved (strictly in order).
- resolve_taken_i  in  1  actual direction.
- history_o  out  HISTORY_LEN  speculative history, registered.
- commit_history_o  out  HISTORY_LEN  architectural history, registered.
- recover_o  out  1  one-cycle pulse; a mispredict was resolved on the previous edge.
- inflight_o  out  $clog2(CKPT_DEPTH+1)  number of unresolved branches.

Behaviour:
- Reset (async, immediate): history_o=0, commit_history_o=0, wr_ptr=rd_ptr=0, inflight_o=0, recover_o=0. pred_ready_o=1, pred_tag_o=0 while in reset.
- pred_ready_o = (inflight_o != CKPT_DEPTH). It is combinational from the count; there is no same-cycle bypass from a resolve.
- Accept = pred_valid_i & pred_ready_o. On accept, at the next edge:
  - history_o <= {history_o[HISTORY_LEN-2:0], pred_taken_i};
  - FIFO[wr_ptr] <= pred_taken_i;
  - wr_ptr increments (wraps mod CKPT_DEPTH);
  - count increments.
- pred_valid_i while not ready: ignored. No shift, no FIFO write. Fetch must stall.
- Resolve = resolve_valid_i & (inflight_o != 0). resolve_valid_i with inflight_o==0 is ignored with no state change.
- On resolve, at the next edge:
  - commit_history_o <= {commit_history_o[HISTORY_LEN-2:0], resolve_taken_i};
  - rd_ptr increments;
  - mispredict = FIFO[rd_ptr] != resolve_taken_i.
- Mispredict (takes priority over any same-cycle accept):
  - history_o <= {commit_history_o[HISTORY_LEN-2:0], resolve_taken_i}, i.e. equal to the new commit_history_o;
  - all younger entries are flushed: wr_ptr <= rd_ptr+1, count <= 0;
  - a same-cycle pred_valid_i is wrong-path and is dropped;
  - recover_o=1 in the following cycle only.
- Correct resolve with a same-cycle accept: both take effect, count unchanged, history_o shifts by the prediction only.
- Correct resolve alone: history_o unchanged, count decrements.
- Back-to-back mispredicts: recover_o pulses on each.
- After any flush, history_o == commit_history_o.
- Invariant: history_o[k-1:0] equals the last k committed-plus-predicted directions, for k up to HISTORY_LEN.
- Pointer width is $clog2(CKPT_DEPTH). Count width is one bit wider so it can distinguish full from empty.

Optional Feature:
- Macro: RIP_BP_HISTORY_STATS_EN.
- When defined:
  - adds output stat_resolved_o [31:0], counting accepted resolves;
  - adds output stat_mispredict_o [31:0], counting mispredicts;
  - both reset to 0, wrap at 2^32, and update at the same edge as the resolve.
- When undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset: assert rst mid-operation with inflight_o=3 -> outputs immediately 0; pred_ready_o=1, recover_o=0, pred_tag_o=0.
- Predictions T,N,T on consecutive cycles -> history_o=16'h0005, inflight_o=3, tags 0,1,2. Then resolve T,N,T -> commit_history_o=16'h0005, inflight_o=0, recover_o never set.
- Four accepted predictions -> pred_ready_o=0. A fifth pred_valid_i=1, T -> history_o unchanged, inflight_o=4. One correct resolve -> pred_ready_o=1.
- From commit 0, predictions T,T,T (history_o=16'h0007); resolve with taken=0 -> next cycle recover_o=1, history_o=16'h0000, commit_history_o=16'h0000, inflight_o=0; the following cycle recover_o=0.
- inflight_o=2; same-cycle accept and correct resolve -> inflight_o stays 2. Same-cycle accept and mispredict -> prediction dropped, inflight_o=0.
- resolve_valid_i=1 with inflight_o=0 -> no change. With RIP_BP_HISTORY_STATS_EN defined, after the sequences above -> stat_resolved_o and stat_mispredict_o match the bench scoreboard.
